// File: rtl/cpu_pkg.sv
// Shared decode-stage definitions: immediate extension modes and
// the immediate-unit state encoding.
package cpu_pkg;

  // Extension mode encodings carried on in_mode
  localparam logic [1:0] EXT_SEXT_FULL = 2'd0;
  localparam logic [1:0] EXT_SEXT_HI   = 2'd1;
  localparam logic [1:0] EXT_SEXT_LO   = 2'd2;
  localparam logic [1:0] EXT_ZEXT      = 2'd3;

  // Immediate unit state: IMM_PFX means a prefix is waiting to be consumed
  typedef enum logic [0:0] {
    IMM_IDLE = 1'b0,
    IMM_PFX  = 1'b1
  } imm_state_e;

endpackage

// File: rtl/imm_ext_core.sv
// Combinational immediate extender: maps (imm, mode) to a DATA_W operand.
module imm_ext_core
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8
) (
  input  logic [IMM_W-1:0]  imm,
  input  logic [1:0]        mode,
  output logic [DATA_W-1:0] result
);

  localparam int HALF_W = IMM_W / 2;

  // The upper-half field is {imm[IMM_W-1], imm[IMM_W-2:HALF_W]}, which is
  // simply the top HALF_W bits of the immediate.
  logic [HALF_W-1:0] hi_half;
  logic [HALF_W-1:0] lo_half;

  assign hi_half = imm[IMM_W-1:HALF_W];
  assign lo_half = imm[HALF_W-1:0];

  // Select the extension; signed casts replicate the field MSB upward
  always_comb begin
    result = '0;
    unique case (mode)
      EXT_SEXT_FULL: result = DATA_W'($signed(imm));
      EXT_SEXT_HI:   result = DATA_W'($signed(hi_half));
      EXT_SEXT_LO:   result = DATA_W'($signed(lo_half));
      EXT_ZEXT:      result = DATA_W'(imm);
      default:       result = '0;
    endcase
  end

endmodule

// File: rtl/imm_extend_unit.sv
// Pipelined immediate generator: one registered output stage with a
// valid/ready handshake and a prefix register for building wide constants.
//
// Handshake: a beat transfers on a cycle where valid && ready are both high
// at the rising edge. The producer holds its payload stable while valid is
// high and ready is low; in_ready = !out_valid || out_ready, so the output
// stage only accepts when it is empty or being drained in the same cycle.
module imm_extend_unit
  import cpu_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int IMM_W  = 8,
  parameter int PFX_W  = DATA_W - IMM_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic [1:0]        in_mode,
  input  logic              in_prefix,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_pfx_used,
  output logic              pfx_overrun
);

  imm_state_e        state_q;
  imm_state_e        state_d;
  logic              accept;
  logic              pfx_load_en;
  logic              overrun_d;
  logic              emit;
  logic              emit_pfx;
  logic              pfx_allowed;
  logic [DATA_W-1:0] ext_result;
  logic [DATA_W-1:0] pfx_data;
  logic [DATA_W-1:0] out_d;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  imm_ext_core #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) u_core (
    .imm    (in_imm),
    .mode   (in_mode),
    .result (ext_result)
  );

  // Prefix register only exists when the operand is wider than the field;
  // otherwise prefix beats are swallowed and the state never leaves IDLE.
  generate
    if (PFX_W > 0) begin : g_pfx
      logic [PFX_W-1:0] pfx_q;
      logic [PFX_W-1:0] pfx_load;

      if (PFX_W > IMM_W) begin : g_zext
        assign pfx_load = {{(PFX_W-IMM_W){1'b0}}, in_imm};
      end else begin : g_trunc
        assign pfx_load = in_imm[PFX_W-1:0];
      end

      // Prefix register: cleared by reset/flush, loaded by accepted prefix beats
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          pfx_q <= '0;
        end else if (flush) begin
          pfx_q <= '0;
        end else if (pfx_load_en) begin
          pfx_q <= pfx_load;
        end
      end

      assign pfx_data    = {pfx_q, in_imm};
      assign pfx_allowed = 1'b1;
    end else begin : g_no_pfx
      assign pfx_data    = in_imm;
      assign pfx_allowed = 1'b0;
    end
  endgenerate

  // Next-state and beat decode: what an accepted beat does in each state
  always_comb begin
    state_d     = state_q;
    pfx_load_en = 1'b0;
    overrun_d   = 1'b0;
    emit        = 1'b0;
    emit_pfx    = 1'b0;
    if (accept) begin
      if (in_prefix) begin
        if (pfx_allowed) begin
          pfx_load_en = 1'b1;
          overrun_d   = (state_q == IMM_PFX);
          state_d     = IMM_PFX;
        end
      end else begin
        emit = 1'b1;
        if (state_q == IMM_PFX) begin
          emit_pfx = 1'b1;
          state_d  = IMM_IDLE;
        end
      end
    end
  end

  // A prefixed beat ignores in_mode and concatenates below the prefix
  assign out_d = emit_pfx ? pfx_data : ext_result;

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IMM_IDLE;
    end else if (flush) begin
      state_q <= IMM_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Output stage: load on emit, drain on out_ready; flush keeps out_data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_pfx_used <= 1'b0;
      pfx_overrun  <= 1'b0;
    end else if (flush) begin
      out_valid   <= 1'b0;
      pfx_overrun <= 1'b0;
    end else begin
      pfx_overrun <= overrun_d;
      if (emit) begin
        out_valid    <= 1'b1;
        out_data     <= out_d;
        out_pfx_used <= emit_pfx;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_imm_extend_unit.sv
// Directed testbench for imm_extend_unit (DATA_W=16, IMM_W=8).
module tb_imm_extend_unit;

  localparam int DATA_W = 16;
  localparam int IMM_W  = 8;

  logic              clk;
  logic              rst_n;
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [IMM_W-1:0]  in_imm;
  logic [1:0]        in_mode;
  logic              in_prefix;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic              out_pfx_used;
  logic              pfx_overrun;

  int checks = 0;
  int errors = 0;

  logic [DATA_W-1:0] exp_q[$];

  imm_extend_unit #(
    .DATA_W (DATA_W),
    .IMM_W  (IMM_W)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_imm       (in_imm),
    .in_mode      (in_mode),
    .in_prefix    (in_prefix),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_pfx_used (out_pfx_used),
    .pfx_overrun  (pfx_overrun)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present one beat for exactly one edge; outputs are sampled 1ns after it
  task automatic send(input logic pfx, input logic [1:0] mode, input logic [7:0] imm);
    in_valid  = 1'b1;
    in_prefix = pfx;
    in_mode   = mode;
    in_imm    = imm;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    in_prefix = 1'b0;
  endtask

  task automatic idle_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin : main
    logic [15:0] pat;
    logic        acc;
    logic        cons;
    int          sent;
    int          got;

    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_imm    = '0;
    in_mode   = 2'd0;
    in_prefix = 1'b0;
    out_ready = 1'b1;
    idle_cycle();
    idle_cycle();

    // Reset state
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_data", 32'(out_data), 32'h0000);
    check("rst_pfx_used", 32'(out_pfx_used), 32'd0);
    check("rst_overrun", 32'(pfx_overrun), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    rst_n = 1'b1;
    idle_cycle();
    check("idle_out_valid", 32'(out_valid), 32'd0);

    // Mode sweep, each result visible right after the accepting edge
    send(1'b0, 2'd0, 8'h85);
    check("m0_85_valid", 32'(out_valid), 32'd1);
    check("m0_85", 32'(out_data), 32'hFF85);
    check("m0_85_pfx", 32'(out_pfx_used), 32'd0);
    send(1'b0, 2'd0, 8'h7F);
    check("m0_7f", 32'(out_data), 32'h007F);
    send(1'b0, 2'd1, 8'hA3);
    check("m1_a3", 32'(out_data), 32'hFFFA);
    send(1'b0, 2'd2, 8'hA3);
    check("m2_a3", 32'(out_data), 32'h0003);
    send(1'b0, 2'd2, 8'h0C);
    check("m2_0c", 32'(out_data), 32'hFFFC);
    send(1'b0, 2'd3, 8'h85);
    check("m3_85", 32'(out_data), 32'h0085);
    check("m3_85_valid", 32'(out_valid), 32'd1);
    idle_cycle();
    check("drain_valid", 32'(out_valid), 32'd0);

    // Prefix concatenation
    send(1'b1, 2'd0, 8'h12);
    check("pfx_no_output", 32'(out_valid), 32'd0);
    check("pfx_no_overrun", 32'(pfx_overrun), 32'd0);
    send(1'b0, 2'd0, 8'h34);
    check("pfx_cat", 32'(out_data), 32'h1234);
    check("pfx_cat_used", 32'(out_pfx_used), 32'd1);
    send(1'b0, 2'd0, 8'h34);
    check("after_pfx", 32'(out_data), 32'h0034);
    check("after_pfx_used", 32'(out_pfx_used), 32'd0);

    // Double prefix: second overwrites the first and pulses overrun once
    send(1'b1, 2'd0, 8'h12);
    check("dpfx_first_ovr", 32'(pfx_overrun), 32'd0);
    send(1'b1, 2'd0, 8'h56);
    check("dpfx_ovr_pulse", 32'(pfx_overrun), 32'd1);
    send(1'b0, 2'd2, 8'h78);
    check("dpfx_ovr_clear", 32'(pfx_overrun), 32'd0);
    check("dpfx_data", 32'(out_data), 32'h5678);
    check("dpfx_used", 32'(out_pfx_used), 32'd1);

    // Backpressure: held output blocks new beats and stays stable
    send(1'b0, 2'd3, 8'hAA);
    check("bp_load", 32'(out_data), 32'h00AA);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_prefix = 1'b1;
    in_imm    = 8'h11;
    in_mode   = 2'd3;
    #1;
    check("bp_in_ready", 32'(in_ready), 32'd0);
    for (int k = 0; k < 5; k++) begin
      idle_cycle();
      check("bp_hold_data", 32'(out_data), 32'h00AA);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
    end
    in_prefix = 1'b0;

    // 10-beat stream with a fixed out_ready pattern; held 0xAA drains first
    exp_q.delete();
    exp_q.push_back(16'h00AA);
    pat  = 16'b1011_0111_1101_1110;
    sent = 0;
    got  = 0;
    for (int cyc = 0; cyc < 80 && got < 11; cyc++) begin
      out_ready = (cyc < 16) ? pat[cyc] : 1'b1;
      in_valid  = (sent < 10);
      in_imm    = 8'(8'h40 + sent);
      in_mode   = 2'd3;
      #1;
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
      if (cons) begin
        if (exp_q.size() == 0) begin
          check("stream_extra", 32'(out_data), 32'hFFFF_FFFF);
        end else begin
          check("stream_data", 32'(out_data), 32'(exp_q.pop_front()));
        end
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        exp_q.push_back(16'(16'h0040 + sent));
        sent++;
      end
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("stream_sent", 32'(sent), 32'd10);
    check("stream_got", 32'(got), 32'd11);
    check("stream_left", 32'(exp_q.size()), 32'd0);
    idle_cycle();

    // Flush mid-prefix; the beat presented alongside the flush is dropped
    send(1'b1, 2'd0, 8'h12);
    flush = 1'b1;
    send(1'b0, 2'd3, 8'h99);
    flush = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_keep_data", 32'(out_data), 32'h0049);
    send(1'b0, 2'd0, 8'h34);
    check("flush_recover", 32'(out_data), 32'h0034);
    check("flush_recover_used", 32'(out_pfx_used), 32'd0);

    // Reset mid-prefix, with overrun pending, clears everything
    send(1'b1, 2'd0, 8'h12);
    rst_n = 1'b0;
    send(1'b1, 2'd0, 8'h56);
    rst_n = 1'b1;
    check("rst2_valid", 32'(out_valid), 32'd0);
    check("rst2_data", 32'(out_data), 32'h0000);
    check("rst2_used", 32'(out_pfx_used), 32'd0);
    check("rst2_overrun", 32'(pfx_overrun), 32'd0);
    send(1'b0, 2'd0, 8'h34);
    check("rst2_recover", 32'(out_data), 32'h0034);
    check("rst2_recover_used", 32'(out_pfx_used), 32'd0);

    idle_cycle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_extend_unit.md
Name: imm_extend_unit

Overview:
- Parametrised, pipelined immediate generator for the decode stage. It takes an IMM_W-bit instruction field and produces a DATA_W-bit operand.
- Four extension modes: full signed, upper-half signed, lower-half signed, and zero-extend.
- New versus the prior extender:
  - one-cycle registered output with a valid/ready handshake, so decode can stall;
  - a prefix mechanism: a prefix beat latches upper bits, and the next immediate is concatenated below them to build full-width constants.

Parameters:
- DATA_W, 16, output operand width; must be at least IMM_W.
- IMM_W, 8, immediate field width; must be even and at least 4.
- PFX_W, DATA_W-IMM_W, width of the prefix register (derived; do not override).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  synchronous active-low reset.
- flush  in  1  pipeline flush; drops the held output and any pending prefix.
- in_valid  in  1  input beat present.
- in_ready  out  1  unit can accept a beat this cycle.
- in_imm  in  IMM_W  raw immediate field.
- in_mode  in  2  0=sext full, 1=sext upper half, 2=sext lower half, 3=zext full.
- in_prefix  in  1  beat is a prefix; in_imm is loaded into the prefix register and no output is produced.
- out_valid  out  1  out_data is valid.
- out_ready  in  1  downstream accepts the output.
- out_data  out  DATA_W  extended operand.
- out_pfx_used  out  1  out_data was built from a prefix.
- pfx_overrun  out  1  one-cycle pulse: a prefix overwrote an unconsumed prefix.

Behaviour:
- Reset (rst_n low at a clock edge):
  - out_valid=0, out_data=0, out_pfx_used=0, pfx_overrun=0;
  - prefix register=0; state=IDLE.
  - Reset takes precedence over flush and over any handshake.
- Handshake:
  - in_ready = !out_valid || out_ready. This is combinational and applies to both prefix and non-prefix beats.
  - A beat is accepted when in_valid && in_ready.
  - out_data and out_pfx_used hold stable while out_valid && !out_ready.
- Latency: an accepted non-prefix beat appears on the outputs at the next edge (1 cycle).
  - out_valid falls after out_ready if no new beat is accepted in the same cycle.
  - Back-to-back throughput is 1 per cycle.
- Extension rules (state IDLE):
  - Mode 0: sign-extend in_imm from bit IMM_W-1.
  - Mode 1: build the IMM_W/2-bit field {in_imm[IMM_W-1], in_imm[IMM_W-2:IMM_W/2]}, then sign-extend it from its MSB.
  - Mode 2: sign-extend in_imm[IMM_W/2-1:0] from bit IMM_W/2-1.
  - Mode 3: zero-extend in_imm.
- State machine (two states):
  - IDLE, accepted prefix beat: prefix register = in_imm, zero-extended or truncated to PFX_W. Go to PREFIXED. No output.
  - PREFIXED, accepted non-prefix beat: out_data = {prefix register, in_imm}; in_mode is ignored; out_pfx_used=1. Go to IDLE.
  - PREFIXED, accepted prefix beat: prefix register is overwritten, pfx_overrun pulses for 1 cycle, stay in PREFIXED.
  - A non-accepted beat changes nothing.
  - A prefix beat accepted while out_valid is held is impossible, because in_ready=0 blocks it.
- PFX_W=0 (DATA_W=IMM_W): prefix beats are accepted and discarded, and the state stays IDLE.
- Flush (rst_n high):
  - next edge: out_valid=0, state=IDLE, prefix register=0;
  - any beat accepted in that same cycle is dropped;
  - out_data keeps its last value.
- Simultaneous output consume and input accept: the new result replaces the old one at the edge, and out_valid stays 1.

Decomposition:
- Shared package cpu_pkg holds:
  - localparams for the mode encodings (EXT_SEXT_FULL=0, EXT_SEXT_HI=1, EXT_SEXT_LO=2, EXT_ZEXT=3);
  - the state encodings IMM_IDLE and IMM_PFX.
- One sub-module is natural: imm_ext_core, purely combinational, mapping (imm, mode) to the DATA_W result. It replaces the old extender.
- The handshake, state machine and prefix register stay in the top module.

Test Plan (DATA_W=16, IMM_W=8, out_ready=1 unless stated):
- Mode sweep:
  - mode0 imm 0x85 -> 0xFF85; mode0 0x7F -> 0x007F;
  - mode1 0xA3 -> 0xFFFA; mode2 0xA3 -> 0x0003; mode2 0x0C -> 0xFFFC;
  - mode3 0x85 -> 0x0085;
  - each result appears one cycle after acceptance.
- Prefix concatenation:
  - prefix 0x12, then mode0 imm 0x34 -> 0x1234 with out_pfx_used=1;
  - next beat imm 0x34 -> 0x0034 with out_pfx_used=0.
- Double prefix: prefix 0x12, prefix 0x56, imm 0x78 -> pfx_overrun pulses once, and the output is 0x5678.
- Backpressure:
  - out_ready=0 with out_valid=1 -> in_ready=0, and out_data is stable for 5 cycles;
  - release -> the next beat flows, with no loss or duplication across a 10-beat stream.
- Flush and reset mid-prefix:
  - prefix 0x12, then flush -> out_valid=0, and a following imm 0x34 -> 0x0034;
  - repeat with rst_n low for 1 cycle -> all outputs 0 and identical recovery.
